// File: rtl/jump_resolve_pkg.sv
// Shared definitions for the jump resolve unit: default sizes and the
// layout of one writeback buffer entry.
package jump_resolve_pkg;

  localparam int DEFAULT_DEPTH = 2;
  localparam int DEFAULT_CNT_W = 16;

  // One pending link-register writeback: destination and value.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/jump_resolve_if.sv
// Bundle of jump FU result inputs, writeback handshake and status outputs.
// The master side drives results and wb_ready; the slave side is the unit.
interface jump_resolve_if
  import jump_resolve_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             finish;
  logic             is_branch;
  logic             cmp_res;
  logic [31:0]      PC_jump;
  logic [31:0]      PC_wb;
  logic [4:0]       rd;
  logic             wb_ready;

  logic             redirect_valid;
  logic [31:0]      redirect_PC;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;

  modport master (
    output finish, is_branch, cmp_res, PC_jump, PC_wb, rd, wb_ready,
    input  redirect_valid, redirect_PC, wb_valid, wb_rd, wb_data,
           busy, overflow, br_total, br_taken
  );

  modport slave (
    input  finish, is_branch, cmp_res, PC_jump, PC_wb, rd, wb_ready,
    output redirect_valid, redirect_PC, wb_valid, wb_rd, wb_data,
           busy, overflow, br_total, br_taken
  );

endinterface

// File: rtl/jump_resolve_wb_fifo.sv
// Writeback buffer for link values. Storage is reset so the head reads zero
// after reset. A push while full is accepted only if the head pops on the
// same edge; the caller detects the dropped case itself.
module jr_wb_fifo
  import jump_resolve_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  wr_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_pop;
  logic            do_push;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer, occupancy and storage update; power-of-two depth wraps pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/jump_resolve.sv
// Resolves jump FU results: issues a registered fetch redirect for taken
// jumps, queues link-register writebacks, and keeps branch statistics.
module jump_resolve
  import jump_resolve_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic          clk,
  input logic          rst,
  jump_resolve_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             taken;
  logic             push;
  logic             pop;
  logic             drop;
  wb_entry_t        wr_entry;
  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             overflow_q;
  logic [CNT_W-1:0] br_total_q;
  logic [CNT_W-1:0] br_taken_q;

  assign taken    = bus.finish & (~bus.is_branch | bus.cmp_res);
  assign push     = bus.finish & ~bus.is_branch & (bus.rd != 5'd0);
  assign pop      = ~empty & bus.wb_ready;
  assign drop     = push & full & ~pop;
  assign wr_entry = '{rd: bus.rd, data: bus.PC_wb};

  jr_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // One-cycle redirect pulse; the target is held between redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= taken;
      if (taken) begin
        redirect_pc_q <= bus.PC_jump;
      end
    end
  end

  // Sticky overflow flag plus saturating branch counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (bus.finish && bus.is_branch) begin
        if (br_total_q != '1) begin
          br_total_q <= br_total_q + CNT_W'(1);
        end
        if (bus.cmp_res && (br_taken_q != '1)) begin
          br_taken_q <= br_taken_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_PC    = redirect_pc_q;
  assign bus.wb_valid       = ~empty;
  assign bus.wb_rd          = head.rd;
  assign bus.wb_data        = head.data;
  assign bus.busy           = (count == CW'(DEPTH));
  assign bus.overflow       = overflow_q;
  assign bus.br_total       = br_total_q;
  assign bus.br_taken       = br_taken_q;

endmodule

// File: tb/tb_jump_resolve.sv
// Directed bench for jump_resolve with DEPTH=2 and narrow counters so that
// saturation is reachable quickly.
module tb_jump_resolve;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  jump_resolve_if #(.CNT_W(CNT_W)) bus ();

  jump_resolve #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Inputs and the outputs expected one edge after applying them.
  typedef struct {
    logic             fin;
    logic             br;
    logic             cmp;
    logic [31:0]      pcj;
    logic [31:0]      pcw;
    logic [4:0]       rd;
    logic             rdy;
    logic             rv;
    logic [31:0]      rpc;
    logic             wv;
    logic [4:0]       wrd;
    logic [31:0]      wdata;
    logic             busy;
    logic             ovf;
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] tkn;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t stim(logic fin, logic br, logic cmp, logic [31:0] pcj,
                                logic [31:0] pcw, logic [4:0] rd, logic rdy);
    vec_t v;
    v = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
          1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, '0, '0};
    v.fin = fin; v.br = br; v.cmp = cmp; v.pcj = pcj;
    v.pcw = pcw; v.rd = rd; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    bus.finish    = v.fin;
    bus.is_branch = v.br;
    bus.cmp_res   = v.cmp;
    bus.PC_jump   = v.pcj;
    bus.PC_wb     = v.pcw;
    bus.rd        = v.rd;
    bus.wb_ready  = v.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, vec_t v);
    check({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(v.rv));
    check({tag, ".redirect_PC"},    bus.redirect_PC,          v.rpc);
    check({tag, ".wb_valid"},       32'(bus.wb_valid),       32'(v.wv));
    if (v.wv) begin
      check({tag, ".wb_rd"},   32'(bus.wb_rd), 32'(v.wrd));
      check({tag, ".wb_data"}, bus.wb_data,    v.wdata);
    end
    check({tag, ".busy"},     32'(bus.busy),     32'(v.busy));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(v.ovf));
    check({tag, ".br_total"}, 32'(bus.br_total), 32'(v.tot));
    check({tag, ".br_taken"}, 32'(bus.br_taken), 32'(v.tkn));
  endtask

  task automatic checkAllZero(string tag);
    check({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'h0);
    check({tag, ".redirect_PC"},    bus.redirect_PC,          32'h0);
    check({tag, ".wb_valid"},       32'(bus.wb_valid),       32'h0);
    check({tag, ".wb_rd"},          32'(bus.wb_rd),          32'h0);
    check({tag, ".wb_data"},        bus.wb_data,              32'h0);
    check({tag, ".busy"},           32'(bus.busy),           32'h0);
    check({tag, ".overflow"},       32'(bus.overflow),       32'h0);
    check({tag, ".br_total"},       32'(bus.br_total),       32'h0);
    check({tag, ".br_taken"},       32'(bus.br_taken),       32'h0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic resetMid(string tag);
    bus.finish   = 1'b0;
    bus.wb_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkAllZero(tag);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs [7];
  vec_t e;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h104, 5'd1, 1'b0,
                1'b1, 32'h200, 1'b1, 5'd1, 32'h104, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1,
                1'b0, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd0, 1'b1,
                1'b0, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd1, 4'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h80, 32'h0, 5'd0, 1'b1,
                1'b1, 32'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd2, 4'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h400, 32'h88, 5'd0, 1'b1,
                1'b1, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd2, 4'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h900, 32'h8, 5'd3, 1'b1,
                1'b0, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd2, 4'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h500, 32'h504, 5'd5, 1'b0,
                1'b1, 32'h500, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd3, 4'd2};

    rst           = 1'b1;
    bus.finish    = 1'b0;
    bus.is_branch = 1'b0;
    bus.cmp_res   = 1'b0;
    bus.PC_jump   = 32'h0;
    bus.PC_wb     = 32'h0;
    bus.rd        = 5'd0;
    bus.wb_ready  = 1'b0;
    #12;
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    $display("[TB] three link pushes into a stalled buffer");
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h600, 32'h1000, 5'd2, 1'b0));
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
          1'b1, 32'h600, 1'b1, 5'd2, 32'h1000, 1'b0, 1'b0, 4'd3, 4'd2};
    checkOutput("ovfA.push1", e);
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h604, 32'h2000, 5'd3, 1'b0));
    e.rpc = 32'h604; e.busy = 1'b1;
    checkOutput("ovfA.push2", e);
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h608, 32'h3000, 5'd4, 1'b0));
    e.rpc = 32'h608; e.ovf = 1'b1;
    checkOutput("ovfA.push3", e);
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1));
    e.rv = 1'b0; e.wrd = 5'd3; e.wdata = 32'h2000; e.busy = 1'b0;
    checkOutput("ovfA.pop1", e);
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1));
    e.wv = 1'b0;
    checkOutput("ovfA.pop2", e);
    resetMid("rstA");

    $display("[TB] push and pop on the same edge while full");
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h700, 32'h10, 5'd6, 1'b0));
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h704, 32'h20, 5'd7, 1'b0));
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
          1'b1, 32'h704, 1'b1, 5'd6, 32'h10, 1'b1, 1'b0, 4'd0, 4'd0};
    checkOutput("both.full", e);
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h708, 32'h30, 5'd8, 1'b1));
    e.rpc = 32'h708; e.wrd = 5'd7; e.wdata = 32'h20;
    checkOutput("both.pushpop", e);
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0));
    e.rv = 1'b0;
    checkOutput("both.hold", e);
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1));
    e.wrd = 5'd8; e.wdata = 32'h30; e.busy = 1'b0;
    checkOutput("both.pop1", e);
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1));
    e.wv = 1'b0;
    checkOutput("both.pop2", e);

    $display("[TB] asynchronous reset with full buffer and pending redirect");
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h800, 32'h40, 5'd9, 1'b0));
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h804, 32'h50, 5'd10, 1'b0));
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
          1'b1, 32'h804, 1'b1, 5'd9, 32'h40, 1'b1, 1'b0, 4'd0, 4'd0};
    checkOutput("rstC.pre", e);
    resetMid("rstC");
    applyStimulus(stim(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0));
    e = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0,
          1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0};
    checkOutput("rstC.idle", e);
    applyStimulus(stim(1'b1, 1'b0, 1'b0, 32'h900, 32'h60, 5'd11, 1'b0));
    e.rv = 1'b1; e.rpc = 32'h900; e.wv = 1'b1; e.wrd = 5'd11; e.wdata = 32'h60;
    checkOutput("rstC.push", e);

    $display("[TB] counter saturation");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(stim(1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd0, 1'b1));
      if (i == 14) begin
        check("sat.total14", 32'(bus.br_total), 32'd14);
      end
      if (i >= 15) begin
        check($sformatf("sat.total%0d", i), 32'(bus.br_total), 32'd15);
        check($sformatf("sat.taken%0d", i), 32'(bus.br_taken), 32'd15);
      end
    end
    applyStimulus(stim(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd0, 1'b1));
    check("sat.total_nt", 32'(bus.br_total), 32'd15);
    check("sat.taken_nt", 32'(bus.br_taken), 32'd15);
    check("sat.redirect_nt", 32'(bus.redirect_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
